// File: rtl/apb_master_bridge.sv
`default_nettype none
// ----------------------------------------------------------------------------
// apb_master_bridge - single-command APB requester for two slaves, with a
// wait-state timeout so a stuck PREADY cannot hang the requester.  Rev 1.0
// ----------------------------------------------------------------------------
module apb_master_bridge #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int SLV_SEL_BIT = 6,
  parameter int TIMEOUT     = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [3:0]        cmd_strb,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL1,
  output logic              PSEL2,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  output logic [3:0]        PSTRB,
  input  logic [DATA_W-1:0] PRDATA1,
  input  logic [DATA_W-1:0] PRDATA2,
  input  logic              PREADY
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  // The counter only ever holds 0..TIMEOUT-1; the abort fires on the edge it would reach TIMEOUT.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [1:0]        state_q,   state_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic              ready_q,   ready_d;
  logic              rvalid_q,  rvalid_d;
  logic [DATA_W-1:0] rdata_q,   rdata_d;
  logic              rerr_q,    rerr_d;
  logic              psel1_q,   psel1_d;
  logic              psel2_q,   psel2_d;
  logic              penable_q, penable_d;
  logic              pwrite_q,  pwrite_d;
  logic [ADDR_W-1:0] paddr_q,   paddr_d;
  logic [DATA_W-1:0] pwdata_q,  pwdata_d;
  logic [3:0]        pstrb_q,   pstrb_d;
  logic              timeout_hit;

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rvalid_d  = 1'b0;
    rdata_d   = rdata_q;
    rerr_d    = rerr_q;
    psel1_d   = psel1_q;
    psel2_d   = psel2_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && ready_q) begin
          state_d  = ST_SETUP;
          psel1_d  = ~cmd_addr[SLV_SEL_BIT];
          psel2_d  = cmd_addr[SLV_SEL_BIT];
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
          pstrb_d  = cmd_write ? cmd_strb : 4'b0000;
        end
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
      end
      ST_ACCESS: begin
        if (PREADY || timeout_hit) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          psel1_d   = 1'b0;
          psel2_d   = 1'b0;
          penable_d = 1'b0;
          rvalid_d  = 1'b1;
          rerr_d    = ~PREADY;
          if (PREADY && !pwrite_q)
            rdata_d = paddr_q[SLV_SEL_BIT] ? PRDATA2 : PRDATA1;
          else
            rdata_d = '0;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rerr_q    <= 1'b0;
      psel1_q   <= 1'b0;
      psel2_q   <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pstrb_q   <= 4'b0000;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rerr_q    <= rerr_d;
      psel1_q   <= psel1_d;
      psel2_q   <= psel2_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
    end
  end

  assign cmd_ready = ready_q;
  assign rsp_valid = rvalid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = rerr_q;
  assign PSEL1     = psel1_q;
  assign PSEL2     = psel2_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign PSTRB     = pstrb_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
`default_nettype none
// Directed testbench for apb_master_bridge: write, read, wait states, timeout,
// reset during ACCESS and back-to-back commands.
module tb_apb_master_bridge;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_strb = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        PSEL1, PSEL2, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA;
  logic [3:0]  PSTRB;
  logic [31:0] PRDATA1 = '0;
  logic [31:0] PRDATA2 = '0;
  logic        PREADY = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 PCLK = ~PCLK;

  apb_master_bridge #(
    .ADDR_W(32), .DATA_W(32), .SLV_SEL_BIT(6), .TIMEOUT(16)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL1(PSEL1), .PSEL2(PSEL2), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PRDATA1(PRDATA1), .PRDATA2(PRDATA2), .PREADY(PREADY)
  );

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_strb = strb;
  endtask

  task automatic test_reset();
    PRESETn = 1'b0;
    repeat (2) tick();
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL reset_cmd_ready got=%b exp=0", cmd_ready); end
    total++; if ({PSEL1, PSEL2, PENABLE, PWRITE, rsp_valid, rsp_err} !== 6'b0) begin bad++; $display("FAIL reset_ctrl got=%b exp=000000", {PSEL1, PSEL2, PENABLE, PWRITE, rsp_valid, rsp_err}); end
    total++; if ({PADDR, PWDATA, PSTRB, rsp_rdata} !== 100'b0) begin bad++; $display("FAIL reset_data got=%h/%h/%h/%h exp=0", PADDR, PWDATA, PSTRB, rsp_rdata); end
    PRESETn = 1'b1;
    tick();
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%b exp=1", cmd_ready); end
  endtask

  task automatic test_write();
    PREADY = 1'b1;
    issue(1'b1, 32'h05, 32'hDEADBEEF, 4'hF);
    tick();
    cmd_valid = 1'b0;
    total++; if ({PSEL1, PSEL2, PENABLE, PWRITE, cmd_ready} !== 5'b10010) begin bad++; $display("FAIL wr_setup_ctrl got=%b exp=10010", {PSEL1, PSEL2, PENABLE, PWRITE, cmd_ready}); end
    total++; if ({PADDR, PWDATA, PSTRB} !== {32'h05, 32'hDEADBEEF, 4'hF}) begin bad++; $display("FAIL wr_setup_bus got=%h/%h/%h exp=5/deadbeef/f", PADDR, PWDATA, PSTRB); end
    tick();
    total++; if ({PSEL1, PSEL2, PENABLE, rsp_valid} !== 4'b1010) begin bad++; $display("FAIL wr_access got=%b exp=1010", {PSEL1, PSEL2, PENABLE, rsp_valid}); end
    tick();
    total++; if ({rsp_valid, rsp_err, cmd_ready, PSEL1, PENABLE} !== 5'b10100) begin bad++; $display("FAIL wr_rsp got=%b exp=10100", {rsp_valid, rsp_err, cmd_ready, PSEL1, PENABLE}); end
    total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL wr_rdata got=%h exp=0", rsp_rdata); end
    tick();
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL wr_rsp_pulse got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_read_slave2();
    PREADY = 1'b1; PRDATA1 = 32'hFFFFFFFF; PRDATA2 = 32'h12345678;
    issue(1'b0, 32'h45, 32'hCAFEF00D, 4'hF);
    tick();
    cmd_valid = 1'b0;
    total++; if ({PSEL1, PSEL2, PENABLE, PWRITE} !== 4'b0100) begin bad++; $display("FAIL rd_setup_ctrl got=%b exp=0100", {PSEL1, PSEL2, PENABLE, PWRITE}); end
    total++; if ({PADDR, PSTRB} !== {32'h45, 4'h0}) begin bad++; $display("FAIL rd_setup_bus got=%h/%h exp=45/0", PADDR, PSTRB); end
    tick();
    total++; if ({PSEL2, PENABLE} !== 2'b11) begin bad++; $display("FAIL rd_access got=%b exp=11", {PSEL2, PENABLE}); end
    tick();
    total++; if ({rsp_valid, rsp_err} !== 2'b10 || rsp_rdata !== 32'h12345678) begin bad++; $display("FAIL rd_rsp got=%b/%h exp=10/12345678", {rsp_valid, rsp_err}, rsp_rdata); end
    PRDATA2 = 32'h0BADF00D;
    tick();
    total++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h12345678) begin bad++; $display("FAIL rd_hold got=%b/%h exp=0/12345678", rsp_valid, rsp_rdata); end
  endtask

  task automatic test_wait_states();
    PREADY = 1'b0; PRDATA1 = 32'hA5A50001; PRDATA2 = 32'h22222222;
    issue(1'b0, 32'h03, 32'h0, 4'h0);
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if ({PSEL1, PSEL2, PENABLE, PWRITE, rsp_valid, cmd_ready} !== 6'b101000 || PADDR !== 32'h03) begin bad++; $display("FAIL wait_stable[%0d] got=%b/%h exp=101000/3", i, {PSEL1, PSEL2, PENABLE, PWRITE, rsp_valid, cmd_ready}, PADDR); end
    end
    PREADY = 1'b1;
    tick();
    total++; if ({rsp_valid, rsp_err} !== 2'b10 || rsp_rdata !== 32'hA5A50001) begin bad++; $display("FAIL wait_rsp got=%b/%h exp=10/a5a50001", {rsp_valid, rsp_err}, rsp_rdata); end
    tick();
  endtask

  task automatic test_timeout();
    PREADY = 1'b0; PRDATA2 = 32'h99999999;
    issue(1'b0, 32'h50, 32'h0, 4'h0);
    tick();
    cmd_valid = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      total++; if ({PSEL2, PENABLE, rsp_valid} !== 3'b110) begin bad++; $display("FAIL timeout_access[%0d] got=%b exp=110", i, {PSEL2, PENABLE, rsp_valid}); end
    end
    tick();
    total++; if ({rsp_valid, rsp_err, PSEL1, PSEL2, PENABLE, cmd_ready} !== 6'b110001) begin bad++; $display("FAIL timeout_abort got=%b exp=110001", {rsp_valid, rsp_err, PSEL1, PSEL2, PENABLE, cmd_ready}); end
    total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL timeout_rdata got=%h exp=0", rsp_rdata); end
    tick();
    total++; if ({rsp_valid, rsp_err} !== 2'b01) begin bad++; $display("FAIL timeout_hold got=%b exp=01", {rsp_valid, rsp_err}); end
  endtask

  task automatic test_reset_mid();
    logic saw_rsp;
    saw_rsp = 1'b0;
    PREADY = 1'b0;
    issue(1'b0, 32'h07, 32'h0, 4'h0);
    tick();
    cmd_valid = 1'b0;
    tick();
    total++; if (PENABLE !== 1'b1) begin bad++; $display("FAIL rstmid_in_access got=%b exp=1", PENABLE); end
    #2 PRESETn = 1'b0;
    #1;
    total++; if ({PSEL1, PSEL2, PENABLE, cmd_ready, rsp_valid} !== 5'b0 || PADDR !== 32'h0) begin bad++; $display("FAIL rstmid_async got=%b/%h exp=00000/0", {PSEL1, PSEL2, PENABLE, cmd_ready, rsp_valid}, PADDR); end
    PREADY = 1'b1;
    repeat (2) begin tick(); saw_rsp = saw_rsp | rsp_valid; end
    PRESETn = 1'b1;
    repeat (2) begin tick(); saw_rsp = saw_rsp | rsp_valid; end
    total++; if (saw_rsp !== 1'b0) begin bad++; $display("FAIL rstmid_no_rsp got=%b exp=0", saw_rsp); end
    issue(1'b1, 32'h0A, 32'h13572468, 4'h3);
    tick();
    cmd_valid = 1'b0;
    total++; if ({PSEL1, PWRITE, PSTRB} !== {2'b11, 4'h3}) begin bad++; $display("FAIL rstmid_wr_setup got=%b/%h exp=11/3", {PSEL1, PWRITE}, PSTRB); end
    repeat (2) tick();
    total++; if ({rsp_valid, rsp_err} !== 2'b10) begin bad++; $display("FAIL rstmid_wr_rsp got=%b exp=10", {rsp_valid, rsp_err}); end
    tick();
  endtask

  task automatic test_back_to_back();
    PREADY = 1'b1; PRDATA1 = 32'h00000011; PRDATA2 = 32'h00000022;
    issue(1'b0, 32'h01, 32'h0, 4'h0);
    tick();
    issue(1'b1, 32'h41, 32'h55AA55AA, 4'hC);
    tick();
    total++; if ({PSEL1, PENABLE} !== 2'b11 || PADDR !== 32'h01) begin bad++; $display("FAIL b2b_first_access got=%b/%h exp=11/1", {PSEL1, PENABLE}, PADDR); end
    tick();
    total++; if ({rsp_valid, cmd_ready, PSEL1, PSEL2} !== 4'b1100 || rsp_rdata !== 32'h11) begin bad++; $display("FAIL b2b_first_rsp got=%b/%h exp=1100/11", {rsp_valid, cmd_ready, PSEL1, PSEL2}, rsp_rdata); end
    tick();
    cmd_valid = 1'b0;
    total++; if ({PSEL1, PSEL2, PENABLE, rsp_valid} !== 4'b0100 || PADDR !== 32'h41 || PSTRB !== 4'hC) begin bad++; $display("FAIL b2b_second_setup got=%b/%h/%h exp=0100/41/c", {PSEL1, PSEL2, PENABLE, rsp_valid}, PADDR, PSTRB); end
    repeat (2) tick();
    total++; if ({rsp_valid, rsp_err} !== 2'b10 || rsp_rdata !== 32'h0) begin bad++; $display("FAIL b2b_second_rsp got=%b/%h exp=10/0", {rsp_valid, rsp_err}, rsp_rdata); end
    tick();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_slave2();
    test_wait_states();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
